// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD to two's-complement encoder.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int BCD_MAX = 9;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FIN
  } state_t;

  // Largest magnitude representable in a signed word; negatives reach one further.
  function automatic int unsigned max_mag(input int unsigned width, input logic neg);
    int unsigned lim;
    lim = (32'd1 << (width - 1));
    if (!neg) begin
      lim = lim - 32'd1;
    end
    return lim;
  endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// One Horner step of the decimal conversion: acc*10 + digit, flagging non-BCD digits.
import bcd_pkg::*;

module bcd_digit_mac #(
  parameter int ACC_W = 14
) (
  input  logic [ACC_W-1:0] acc_in,
  input  bcd_digit_t       digit,
  output logic [ACC_W-1:0] acc_out,
  output logic             digit_bad
);

  // Times ten as two shifts keeps this a pair of adders rather than a multiplier.
  assign acc_out   = (acc_in << 3) + (acc_in << 1) + {{(ACC_W-4){1'b0}}, digit};
  assign digit_bad = (digit > 4'(BCD_MAX));

endmodule

// File: rtl/bcd_2c_enc.sv
// Digit-serial packed-BCD plus sign to two's-complement encoder with start/busy/done handshake.
import bcd_pkg::*;

module bcd_2c_enc #(
  parameter int NDIG  = 4,
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sign,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  dout,
  output logic              err
);

  localparam int ACC_W = $clog2(10**NDIG);
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [WIDTH-1:0] ONE = 1;

  state_t            state_q;
  logic              sign_q;
  logic [4*NDIG-1:0] bcd_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              bad_q;
  logic              digitBad;
  logic              outOfRange;
  bcd_digit_t        curDigit;

  // The latched word shifts left each step so the MSD always sits in the top nibble.
  assign curDigit = bcd_q[4*NDIG-1 -: 4];

  bcd_digit_mac #(.ACC_W(ACC_W)) u_mac (
    .acc_in    (acc_q),
    .digit     (curDigit),
    .acc_out   (acc_d),
    .digit_bad (digitBad)
  );

  assign outOfRange = (32'(acc_q) > max_mag(WIDTH, sign_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dout    <= '0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sign_q  <= sign;
            bcd_q   <= bcd_in;
            acc_q   <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            busy    <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          acc_q <= acc_d;
          bad_q <= bad_q | digitBad;
          bcd_q <= bcd_q << 4;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NDIG - 1)) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          // A bad digit still got accumulated, so the flag must win over the range test.
          if (bad_q || outOfRange) begin
            err  <= 1'b1;
            dout <= '0;
          end else begin
            err  <= 1'b0;
            dout <= sign_q ? (~acc_q[WIDTH-1:0] + ONE) : acc_q[WIDTH-1:0];
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_2c_enc.sv
// Scoreboard bench for bcd_2c_enc: expectations queued at launch, checked on each done pulse.
module tb_bcd_2c_enc;

  localparam int NDIG  = 4;
  localparam int WIDTH = 8;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sign;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic [7:0]  dout;
  logic        err;

  int checkCount = 0;
  int failCount  = 0;
  int doneCount  = 0;

  logic [8:0] expQueue[$];

  bcd_2c_enc #(.NDIG(NDIG), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .sign   (sign),
    .bcd_in (bcd_in),
    .busy   (busy),
    .done   (done),
    .dout   (dout),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference result as {err, dout}, computed from the decimal value of the digits.
  function automatic logic [8:0] refModel(input logic s, input logic [15:0] bcd);
    int mag;
    bit bad;
    logic [3:0] d;
    mag = 0;
    bad = 0;
    for (int i = 3; i >= 0; i--) begin
      d = bcd[4*i +: 4];
      if (d > 4'd9) bad = 1;
      mag = mag * 10 + int'(d);
    end
    if (bad || mag > (s ? 128 : 127)) return {1'b1, 8'h00};
    if (s) return {1'b0, 8'(256 - mag)};
    return {1'b0, 8'(mag)};
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      logic [8:0] exp;
      doneCount++;
      if (expQueue.size() == 0) begin
        checkOutput("unexpectedDone", 32'd1, 32'd0);
      end else begin
        exp = expQueue.pop_front();
        checkOutput("dout", 32'(dout), 32'(exp[7:0]));
        checkOutput("err", 32'(err), 32'(exp[8]));
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic [15:0] bcd, input bit holdStart, input bit scramble);
    int busyCycles;
    int latency;
    int doneBefore;
    bit seen;
    busyCycles = 0;
    latency    = 0;
    seen       = 0;
    doneBefore = doneCount;
    expQueue.push_back(refModel(s, bcd));
    @(negedge clk);
    sign   = s;
    bcd_in = bcd;
    start  = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (!holdStart) start = 1'b0;
      if (scramble) begin
        bcd_in = 16'($urandom);
        sign   = 1'($urandom);
      end
      if (done) begin
        seen    = 1;
        latency = c + 1;
        start   = 1'b0;
      end else if (busy) begin
        busyCycles++;
      end
    end
    if (!seen) begin
      checkOutput("doneTimeout", 32'd0, 32'd1);
      void'(expQueue.pop_back());
    end else begin
      checkOutput("doneLatency", 32'(latency), 32'(NDIG + 2));
      checkOutput("busyLen", 32'(busyCycles), 32'(NDIG + 1));
    end
    repeat (2) @(negedge clk);
    checkOutput("donePulses", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("busyIdle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneBefore;
    reset  = 1'b1;
    start  = 1'b0;
    sign   = 1'b0;
    bcd_in = 16'h0000;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstDout", 32'(dout), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 16'h0123, 0, 0);
    applyStimulus(1'b1, 16'h0005, 0, 0);
    applyStimulus(1'b1, 16'h0107, 0, 0);
    applyStimulus(1'b0, 16'h0020, 0, 0);
    applyStimulus(1'b1, 16'h0128, 0, 0);
    applyStimulus(1'b0, 16'h0128, 0, 0);
    applyStimulus(1'b1, 16'h0129, 0, 0);
    applyStimulus(1'b1, 16'h0000, 0, 0);
    applyStimulus(1'b0, 16'h0127, 0, 0);
    applyStimulus(1'b0, 16'h00A1, 0, 0);
    applyStimulus(1'b1, 16'hF000, 0, 0);
    applyStimulus(1'b0, 16'h0099, 1, 0);
    applyStimulus(1'b0, 16'h0045, 0, 1);
    applyStimulus(1'b1, 16'h0063, 0, 1);

    // Leave a nonzero result behind so the reset clearing is observable.
    applyStimulus(1'b0, 16'h0123, 0, 0);
    doneBefore = doneCount;
    @(negedge clk);
    sign   = 1'b1;
    bcd_in = 16'h0077;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    checkOutput("midRstDout", 32'(dout), 32'd0);
    checkOutput("midRstErr", 32'(err), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("noDoneAfterRst", 32'(doneCount - doneBefore), 32'd0);

    applyStimulus(1'b1, 16'h0077, 0, 0);

    checkOutput("sbEmpty", 32'(expQueue.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
